// File: rtl/mips_pkg.sv
// Shared encodings for the MIPS pipeline: ALUOp, ALU control codes, funct codes, reset constants.
package mips_pkg;

    typedef enum logic [1:0] {
        ALUOP_ADD   = 2'b00,
        ALUOP_SUB   = 2'b01,
        ALUOP_FUNCT = 2'b10,
        ALUOP_RSVD  = 2'b11
    } alu_op_e;

    localparam logic [3:0] ALU_AND = 4'b0000;
    localparam logic [3:0] ALU_OR  = 4'b0001;
    localparam logic [3:0] ALU_ADD = 4'b0010;
    localparam logic [3:0] ALU_SUB = 4'b0110;
    localparam logic [3:0] ALU_SLT = 4'b0111;
    localparam logic [3:0] ALU_NOP = 4'b1111;

    localparam logic [5:0] FUNCT_ADD = 6'b100000;
    localparam logic [5:0] FUNCT_SUB = 6'b100010;
    localparam logic [5:0] FUNCT_AND = 6'b100100;
    localparam logic [5:0] FUNCT_OR  = 6'b100101;
    localparam logic [5:0] FUNCT_SLT = 6'b101010;

    localparam logic [3:0] EX_ALU_CTRL_RST = 4'b0000;

endpackage

// File: rtl/alu_control.sv
// Combinational ALUOp/funct decode into the 4-bit ALU control code.
module alu_control
    import mips_pkg::*;
(
    input  logic [1:0] alu_op,
    input  logic [5:0] funct,
    output logic [3:0] alu_ctrl
);

    always_comb begin
        alu_ctrl = ALU_NOP;
        case (alu_op_e'(alu_op))
            ALUOP_ADD:   alu_ctrl = ALU_ADD;
            ALUOP_SUB:   alu_ctrl = ALU_SUB;
            ALUOP_FUNCT: begin
                case (funct)
                    FUNCT_ADD: alu_ctrl = ALU_ADD;
                    FUNCT_SUB: alu_ctrl = ALU_SUB;
                    FUNCT_AND: alu_ctrl = ALU_AND;
                    FUNCT_OR:  alu_ctrl = ALU_OR;
                    FUNCT_SLT: alu_ctrl = ALU_SLT;
                    default:   alu_ctrl = ALU_NOP;
                endcase
            end
            default:     alu_ctrl = ALU_NOP;
        endcase
    end

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register: operand/control capture, ALU control decode, imm select, load-use bubble.
// Optional operand forwarding from EX/MEM when ID_EX_FWD_EN is defined.
module id_ex_stage
    import mips_pkg::*;
#(
    parameter int DW = 32,
    parameter int RW = 5
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          stall,
    input  logic          flush,
    input  logic          id_valid,
    input  logic [DW-1:0] id_rs_data,
    input  logic [DW-1:0] id_rt_data,
    input  logic [15:0]   id_imm16,
    input  logic [RW-1:0] id_rs_addr,
    input  logic [RW-1:0] id_rt_addr,
    input  logic [RW-1:0] id_rd_addr,
    input  logic [1:0]    id_alu_op,
    input  logic [5:0]    id_funct,
    input  logic          id_alu_src,
    input  logic          id_reg_dst,
    input  logic          id_reg_write,
    input  logic          id_mem_read,
    input  logic          id_mem_write,
    input  logic          id_mem_to_reg,
`ifdef ID_EX_FWD_EN
    input  logic [DW-1:0] fwd_ex_result,
    input  logic          fwd_mem_we,
    input  logic [RW-1:0] fwd_mem_addr,
    input  logic [DW-1:0] fwd_mem_result,
`endif
    output logic          ex_valid,
    output logic [DW-1:0] ex_rs,
    output logic [DW-1:0] ex_rt,
    output logic [3:0]    ex_alu_control,
    output logic [DW-1:0] ex_store_data,
    output logic [RW-1:0] ex_wb_addr,
    output logic          ex_reg_write,
    output logic          ex_mem_read,
    output logic          ex_mem_write,
    output logic          ex_mem_to_reg,
    output logic          load_use_hazard
);

    logic [DW-1:0] rs_value, rt_value, imm_ext, alu_b;
    logic [RW-1:0] wb_addr;
    logic [3:0]    alu_ctrl_d;
    logic          load_bubble;

`ifdef ID_EX_FWD_EN
    // A load in EX has no result yet; that case is covered by the hazard bubble instead.
    logic ex_fwd_ok;
    assign ex_fwd_ok = ex_valid & ex_reg_write & ~ex_mem_read;

    always_comb begin
        rs_value = id_rs_data;
        if (ex_fwd_ok && ex_wb_addr == id_rs_addr && id_rs_addr != '0)
            rs_value = fwd_ex_result;
        else if (fwd_mem_we && fwd_mem_addr == id_rs_addr && id_rs_addr != '0)
            rs_value = fwd_mem_result;
    end

    always_comb begin
        rt_value = id_rt_data;
        if (ex_fwd_ok && ex_wb_addr == id_rt_addr && id_rt_addr != '0)
            rt_value = fwd_ex_result;
        else if (fwd_mem_we && fwd_mem_addr == id_rt_addr && id_rt_addr != '0)
            rt_value = fwd_mem_result;
    end
`else
    assign rs_value = id_rs_data;
    assign rt_value = id_rt_data;
`endif

    alu_control u_alu_control (
        .alu_op   (id_alu_op),
        .funct    (id_funct),
        .alu_ctrl (alu_ctrl_d)
    );

    assign imm_ext = {{(DW-16){id_imm16[15]}}, id_imm16};
    assign alu_b   = id_alu_src ? imm_ext : rt_value;
    assign wb_addr = id_reg_dst ? id_rd_addr : id_rt_addr;

    assign load_use_hazard = ex_valid & ex_mem_read & (ex_wb_addr != '0) &
                             ((ex_wb_addr == id_rs_addr) | (ex_wb_addr == id_rt_addr));

    // Flush always bubbles; hazard and empty ID only bubble when not stalled.
    assign load_bubble = flush | (~stall & (load_use_hazard | ~id_valid));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ex_valid       <= 1'b0;
            ex_rs          <= '0;
            ex_rt          <= '0;
            ex_alu_control <= EX_ALU_CTRL_RST;
            ex_store_data  <= '0;
            ex_wb_addr     <= '0;
            ex_reg_write   <= 1'b0;
            ex_mem_read    <= 1'b0;
            ex_mem_write   <= 1'b0;
            ex_mem_to_reg  <= 1'b0;
        end else if (load_bubble) begin
            ex_valid       <= 1'b0;
            ex_rs          <= '0;
            ex_rt          <= '0;
            ex_alu_control <= EX_ALU_CTRL_RST;
            ex_store_data  <= '0;
            ex_wb_addr     <= '0;
            ex_reg_write   <= 1'b0;
            ex_mem_read    <= 1'b0;
            ex_mem_write   <= 1'b0;
            ex_mem_to_reg  <= 1'b0;
        end else if (!stall) begin
            ex_valid       <= 1'b1;
            ex_rs          <= rs_value;
            ex_rt          <= alu_b;
            ex_alu_control <= alu_ctrl_d;
            ex_store_data  <= rt_value;
            ex_wb_addr     <= wb_addr;
            ex_reg_write   <= id_reg_write;
            ex_mem_read    <= id_mem_read;
            ex_mem_write   <= id_mem_write;
            ex_mem_to_reg  <= id_mem_to_reg;
        end
    end

endmodule
